dcp_serializer: RTL and testbench

DCP_SERIALIZER -- requirements
Module: dcp_serializer

---
 rtl/dcp_serializer_pkg.sv | 21 ++
 rtl/dcp_serializer.sv | 92 +++++++++
 tb/tb_dcp_serializer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcp_serializer_pkg.sv
// Shared definitions for the decoupled-channel width serializer.
//   dcp_state_e  : serializer FSM state (IDLE / SHIFT)
//   dcp_ratio    : number of narrow beats per wide word
//   dcp_width_ok : elaboration-time legality check of the width pair
package DcpPkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } dcp_state_e;

  function automatic int dcp_ratio(input int in_dw, input int out_dw);
    return in_dw / out_dw;
  endfunction

  // Wide width must be an exact multiple of the narrow width, at least 2x.
  function automatic bit dcp_width_ok(input int in_dw, input int out_dw);
    return (out_dw > 0) && ((in_dw % out_dw) == 0) && ((in_dw / out_dw) >= 2);
  endfunction

endpackage

// File: rtl/dcp_serializer.sv
// Wide-to-narrow decoupled serializer. A captured IN_DW word is emitted as
// RATIO consecutive OUT_DW beats, lowest slice first when LSB_FIRST=1.
// Ports:
//   iClk, iRst_n                          clock, async active-low reset
//   iDcpIn_vld/iDcpIn_pld  -> iDcpIn_rdy  wide upstream channel (slave)
//   oDcpOut_vld/oDcpOut_pld <- oDcpOut_rdy narrow downstream channel (master)
// Output payload comes only from the hold register; the single
// combinational through-path is oDcpOut_rdy -> iDcpIn_rdy on the last beat.
module dcp_serializer #(
  parameter int IN_DW     = 32,
  parameter int OUT_DW    = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iDcpIn_vld,
  input  logic [IN_DW-1:0]  iDcpIn_pld,
  output logic              iDcpIn_rdy,
  output logic              oDcpOut_vld,
  output logic [OUT_DW-1:0] oDcpOut_pld,
  input  logic              oDcpOut_rdy
);
  import DcpPkg::*;

  localparam int RATIO = dcp_ratio(IN_DW, OUT_DW);
  localparam int CW    = $clog2(RATIO);
  localparam int IW    = $clog2(IN_DW);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  if (!dcp_width_ok(IN_DW, OUT_DW)) begin : g_bad_width
    $error("dcp_serializer: IN_DW must be a multiple (>=2x) of OUT_DW");
  end

  dcp_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [IN_DW-1:0]  hold_q;
  logic              rel_q;     // set on the first edge after reset release
  logic              in_fire, out_fire, last;
  logic [CW-1:0]     sel;
  logic [IW-1:0]     idx;

  assign last     = (cnt_q == LAST);
  assign in_fire  = iDcpIn_vld & iDcpIn_rdy;
  assign out_fire = oDcpOut_vld & oDcpOut_rdy;

  // Beat counter maps to a slice index; MSB-first just mirrors it.
  assign sel = LSB_FIRST ? cnt_q : (LAST - cnt_q);
  assign idx = IW'(sel) * IW'(OUT_DW);

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_fire) state_d = SHIFT;
      SHIFT:   if (out_fire && last && !in_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    oDcpOut_vld = (state_q == SHIFT);
    oDcpOut_pld = hold_q[idx +: OUT_DW];
    iDcpIn_rdy  = rel_q & ((state_q == IDLE) |
                           ((state_q == SHIFT) & last & oDcpOut_rdy));
  end

  // Datapath: capture reloads the counter; a non-final beat advances it.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else if (in_fire) begin
      hold_q <= iDcpIn_pld;
      cnt_q  <= '0;
    end else if (out_fire && !last) begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) rel_q <= 1'b0;
    else         rel_q <= 1'b1;
  end

endmodule

// File: tb/tb_dcp_serializer.sv
// Directed bench for dcp_serializer: LSB-first instance (a_*) and an
// MSB-first instance (b_*) sharing clock and reset. Inputs change 1ns after
// the rising edge; outputs are sampled on the falling edge.
module tb_dcp_serializer;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  logic        a_in_vld = 1'b0, a_in_rdy, a_out_vld, a_out_rdy = 1'b1;
  logic [31:0] a_in_pld = 32'h0;
  logic [7:0]  a_out_pld;
  logic        b_in_vld = 1'b0, b_in_rdy, b_out_vld, b_out_rdy = 1'b1;
  logic [31:0] b_in_pld = 32'h0;
  logic [7:0]  b_out_pld;

  dcp_serializer #(.IN_DW(32), .OUT_DW(8), .LSB_FIRST(1'b1)) u_dut_a (
    .iClk(gclk), .iRst_n(grst_n),
    .iDcpIn_vld(a_in_vld), .iDcpIn_pld(a_in_pld), .iDcpIn_rdy(a_in_rdy),
    .oDcpOut_vld(a_out_vld), .oDcpOut_pld(a_out_pld), .oDcpOut_rdy(a_out_rdy)
  );

  dcp_serializer #(.IN_DW(32), .OUT_DW(8), .LSB_FIRST(1'b0)) u_dut_b (
    .iClk(gclk), .iRst_n(grst_n),
    .iDcpIn_vld(b_in_vld), .iDcpIn_pld(b_in_pld), .iDcpIn_rdy(b_in_rdy),
    .oDcpOut_vld(b_out_vld), .oDcpOut_pld(b_out_pld), .oDcpOut_rdy(b_out_rdy)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] got[$];

  logic [7:0] e_1122[4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] e_msb[4]   = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] e_5566[4]  = '{8'h55, 8'h66, 8'h77, 8'h88};
  logic [31:0] rnd_w[4]  = '{32'hC3C2C1C0, 32'hC7C6C5C4, 32'h5A5B5C5D, 32'hF0E1D2C3};
  logic [7:0] e_rnd[16]  = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7,
                             8'h5D, 8'h5C, 8'h5B, 8'h5A, 8'hC3, 8'hD2, 8'hE1, 8'hF0};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, act, exp);
    end
  endtask

  // Beat collector plus hold check: a stalled beat must stay put.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_pld  = 8'h0;
  always @(negedge gclk) begin
    if (grst_n) begin
      if (prev_hold) begin
        chk("hold_vld", 32'(a_out_vld), 32'd1);
        chk("hold_pld", 32'(a_out_pld), 32'(prev_pld));
      end
      if (a_out_vld && a_out_rdy) got.push_back(a_out_pld);
      prev_hold = a_out_vld && !a_out_rdy;
      prev_pld  = a_out_pld;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send_a(input logic [31:0] w);
    bit ok = 1'b0;
    a_in_vld = 1'b1;
    a_in_pld = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge gclk);
      if (a_in_rdy) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge gclk); #1;
    a_in_vld = 1'b0;
    a_in_pld = 32'hDEADBEEF;
  endtask

  initial begin
    // ---- reset ----
    for (int i = 0; i < 5; i++) begin
      @(negedge gclk);
      chk("rst_vld", 32'(a_out_vld), 32'd0);
      chk("rst_rdy", 32'(a_in_rdy), 32'd0);
      chk("rst_pld", 32'(a_out_pld), 32'd0);
    end
    @(posedge gclk); #1;
    grst_n = 1'b1;
    @(negedge gclk);
    chk("rdy_edge1", 32'(a_in_rdy), 32'd0);
    @(negedge gclk);
    chk("rdy_edge2", 32'(a_in_rdy), 32'd1);
    chk("rdy_edge2_b", 32'(b_in_rdy), 32'd1);
    @(posedge gclk); #1;

    // ---- single word, LSB first ----
    send_a(32'h44332211);
    for (int k = 0; k < 4; k++) begin
      @(negedge gclk);
      chk("single_vld", 32'(a_out_vld), 32'd1);
      chk("single_pld", 32'(a_out_pld), 32'(e_1122[k]));
    end
    @(negedge gclk);
    chk("single_idle", 32'(a_out_vld), 32'd0);
    @(posedge gclk); #1;

    // ---- streaming, no bubbles ----
    fork
      begin
        send_a(32'h03020100);
        send_a(32'h07060504);
        send_a(32'h0B0A0908);
      end
      begin
        for (int i = 0; i < 20; i++) begin
          @(negedge gclk);
          if (a_out_vld) break;
        end
        for (int k = 0; k < 12; k++) begin
          chk("stream_vld", 32'(a_out_vld), 32'd1);
          chk("stream_pld", 32'(a_out_pld), 32'(k));
          chk("stream_rdy", 32'(a_in_rdy), 32'((k % 4) == 3));
          if (k < 11) @(negedge gclk);
        end
      end
    join
    @(negedge gclk);
    chk("stream_idle", 32'(a_out_vld), 32'd0);
    @(posedge gclk); #1;

    // ---- back-pressure: ready toggles every 2 cycles ----
    got.delete();
    fork
      begin
        send_a(32'h13121110);
        send_a(32'h17161514);
        send_a(32'h1B1A1918);
      end
      begin
        for (int c = 0; c < 400 && got.size() < 12; c++) begin
          @(posedge gclk); #1;
          a_out_rdy = ((c / 2) % 2) == 0;
        end
      end
    join
    a_out_rdy = 1'b1;
    chk("bp_count", 32'(got.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      chk("bp_byte", (i < got.size()) ? 32'(got[i]) : 32'hFFFFFFFF, 32'h10 + 32'(i));
    @(posedge gclk); #1;

    // ---- MSB first (instance b) ----
    b_in_vld = 1'b1;
    b_in_pld = 32'hA1B2C3D4;
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge gclk);
        if (b_in_rdy) begin ok = 1'b1; break; end
      end
      chk("msb_accept", 32'(ok), 32'd1);
    end
    @(posedge gclk); #1;
    b_in_vld = 1'b0;
    b_in_pld = 32'h12345678;
    for (int k = 0; k < 4; k++) begin
      @(negedge gclk);
      chk("msb_vld", 32'(b_out_vld), 32'd1);
      chk("msb_pld", 32'(b_out_pld), 32'(e_msb[k]));
    end
    @(negedge gclk);
    chk("msb_idle", 32'(b_out_vld), 32'd0);
    @(posedge gclk); #1;

    // ---- reset in the middle of a word ----
    send_a(32'h44332211);
    for (int k = 0; k < 2; k++) begin
      @(negedge gclk);
      chk("mid_pre_pld", 32'(a_out_pld), 32'(e_1122[k]));
    end
    @(posedge gclk); #1;
    grst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(a_out_vld), 32'd0);
    chk("mid_rst_pld", 32'(a_out_pld), 32'd0);
    chk("mid_rst_rdy", 32'(a_in_rdy), 32'd0);
    repeat (3) @(posedge gclk);
    #1;
    grst_n = 1'b1;
    got.delete();
    send_a(32'h88776655);
    for (int k = 0; k < 4; k++) begin
      @(negedge gclk);
      chk("mid_post_pld", 32'(a_out_pld), 32'(e_5566[k]));
    end
    @(negedge gclk);
    chk("mid_post_idle", 32'(a_out_vld), 32'd0);
    #1;
    chk("mid_post_count", 32'(got.size()), 32'd4);
    chk("mid_post_first", (got.size() > 0) ? 32'(got[0]) : 32'hFFFFFFFF, 32'h55);
    @(posedge gclk); #1;

    // ---- random consumer ----
    got.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) send_a(rnd_w[i]);
      end
      begin
        for (int c = 0; c < 2000 && got.size() < 16; c++) begin
          @(posedge gclk); #1;
          a_out_rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    a_out_rdy = 1'b1;
    chk("rnd_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      chk("rnd_byte", (i < got.size()) ? 32'(got[i]) : 32'hFFFFFFFF, 32'(e_rnd[i]));

    repeat (2) @(posedge gclk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
